launch_buffer: RTL and testbench

LAUNCH_BUFFER -- requirements
Module: launch_buffer

---
 rtl/launch_buffer.sv | 185 ++++++++++++++++++
 tb/tb_launch_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/launch_buffer.sv
// Baud-paced launch buffer: a circular store feeding a launcher one word per
// accepted bps tick, with a valid/ready handshake toward the launcher.
module launch_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              bps_tick_i,
  input  logic              tx_ready_i,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              overflow_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   LVL_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DAT_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] mem_r [DEPTH];
  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic [ADDR_W:0]   level_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              ovf_r;
  logic              tx_valid_r;
  logic [DATA_W-1:0] tx_data_r;
  logic              push_s;
  logic              hs_s;
  logic              load_s;

  // The full check also guarantees the entry being launched is never overwritten.
  assign push_s = wr_en_i && !full_r && !clr_i;
  assign hs_s   = (state_r == ST_PRESENT) && tx_ready_i && !clr_i;

  // Read FSM next state; ticks only matter in IDLE and need a stored word.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    if (clr_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bps_tick_i && !empty_r) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          load_s      = 1'b1;
          state_nxt_s = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (tx_ready_i) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_PRESENT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Next fill level; a simultaneous push and handshake cancel out.
  always_comb begin
    level_nxt_s = level_r;
    if (clr_i) begin
      level_nxt_s = LVL_ZERO;
    end else if (push_s && !hs_s) begin
      level_nxt_s = level_r + LVL_ONE;
    end else if (hs_s && !push_s) begin
      level_nxt_s = level_r - LVL_ONE;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // FSM state and registered valid, which is high exactly in PRESENT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      tx_valid_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_valid_r <= (state_nxt_s == ST_PRESENT);
    end
  end

  // Write and read pointers, both wrapping naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (clr_i) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (hs_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Level and the full/empty flags derived from the next level.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      level_r <= LVL_ZERO;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == LVL_FULL);
      empty_r <= (level_nxt_s == LVL_ZERO);
    end
  end

  // Sticky flag for pushes dropped while full.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf_r <= 1'b0;
    end else if (clr_i) begin
      ovf_r <= 1'b0;
    end else if (wr_en_i && full_r) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Output word captured in LOAD and held through PRESENT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_data_r <= DAT_ZERO;
    end else if (load_s && !clr_i) begin
      tx_data_r <= mem_r[rd_ptr_r];
    end else begin
      tx_data_r <= tx_data_r;
    end
  end

  // Storage array; deliberately not reset so it maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data_i;
    end
  end

  assign tx_valid_o = tx_valid_r;
  assign tx_data_o  = tx_data_r;
  assign full_o     = full_r;
  assign empty_o    = empty_r;
  assign level_o    = level_r;
  assign rd_addr_o  = rd_ptr_r;
  assign overflow_o = ovf_r;

endmodule

// File: tb/tb_launch_buffer.sv
// Bench for launch_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_launch_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          clr_i = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [DW-1:0] wr_data_i = 8'h00;
  logic          bps_tick_i = 1'b0;
  logic          tx_ready_i = 1'b0;
  logic          tx_valid_o;
  logic [DW-1:0] tx_data_o;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   level_o;
  logic [AW-1:0] rd_addr_o;
  logic          overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stored words as a queue, launch progress as cycles since tick.
  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;
  int            m_rd_cnt = 0;
  int            m_stage = 0;

  launch_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .wr_en_i(wr_en_i),
    .wr_data_i(wr_data_i), .bps_tick_i(bps_tick_i), .tx_ready_i(tx_ready_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .full_o(full_o),
    .empty_o(empty_o), .level_o(level_o), .rd_addr_o(rd_addr_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      q.delete();
      m_ovf    = 1'b0;
      m_rd_cnt = 0;
      m_stage  = 0;
    end else if (clr_i) begin
      q.delete();
      m_ovf    = 1'b0;
      m_rd_cnt = 0;
      m_stage  = 0;
    end else begin
      bit hs, pushed, start;
      int sz;
      sz     = q.size();
      hs     = (m_stage == 2) && tx_ready_i;
      pushed = wr_en_i && (sz < DEPTH);
      start  = (m_stage == 0) && bps_tick_i && (sz > 0);
      if (wr_en_i && !pushed) m_ovf = 1'b1;
      if (hs) begin
        void'(q.pop_front());
        m_rd_cnt++;
        m_stage = 0;
      end else if (m_stage == 1) begin
        m_stage = 2;
      end
      if (start) m_stage = 1;
      if (pushed) q.push_back(wr_data_i);
    end
  end

  always @(negedge clk) begin
    chk("valid", tx_valid_o, (m_stage == 2));
    if (m_stage == 2) chk("data", tx_data_o, q[0]);
    chk("level", level_o, q.size());
    chk("full", full_o, (q.size() == DEPTH));
    chk("empty", empty_o, (q.size() == 0));
    chk("rd_addr", rd_addr_o, m_rd_cnt % DEPTH);
    chk("overflow", overflow_o, m_ovf);
  end

  task automatic step(input logic we, input logic [DW-1:0] d, input logic tk,
                      input logic rdy, input logic cl);
    wr_en_i = we; wr_data_i = d; bps_tick_i = tk; tx_ready_i = rdy; clr_i = cl;
    @(posedge clk);
    #1;
    wr_en_i = 1'b0; bps_tick_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic launch(input logic [DW-1:0] exp_d, input logic [AW-1:0] exp_addr);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("lat_load", tx_valid_o, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("lat_present", tx_valid_o, 1'b1);
    chk("lit_data", tx_data_o, exp_d);
    chk("lit_rd_addr", rd_addr_o, exp_addr);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("lat_done", tx_valid_o, 1'b0);
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "_valid"}, tx_valid_o, 1'b0);
    chk({nm, "_data"}, tx_data_o, 8'h00);
    chk({nm, "_level"}, level_o, 3'd0);
    chk({nm, "_empty"}, empty_o, 1'b1);
    chk({nm, "_full"}, full_o, 1'b0);
    chk({nm, "_ovf"}, overflow_o, 1'b0);
    chk({nm, "_rd_addr"}, rd_addr_o, 2'd0);
  endtask

  initial begin
    #2 rst_i = 1'b0;
    #1 check_reset_values("rst");
    @(posedge clk);
    #1 rst_i = 1'b1;

    // Three words launched in order, valid two cycles after each tick.
    step(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b1, 1'b0);
    chk("lvl3", level_o, 3'd3);
    for (int i = 0; i < 3; i++) launch(8'h41 + 8'(i), 2'(i));
    chk("drained_level", level_o, 3'd0);
    chk("drained_empty", empty_o, 1'b1);

    // Overflow: fifth push dropped, only words 1..4 come out.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    chk("full_at4", full_o, 1'b1);
    chk("no_ovf_at4", overflow_o, 1'b0);
    step(1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
    chk("ovf_set", overflow_o, 1'b1);
    chk("lvl_capped", level_o, 3'd4);
    for (int i = 0; i < 4; i++) launch(8'(i + 1), 2'((3 + i) % 4));
    chk("ovf_sticky", overflow_o, 1'b1);
    chk("ovf_drained", empty_o, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("clr_ovf", overflow_o, 1'b0);
    chk("clr_rd_addr", rd_addr_o, 2'd0);

    // Pointer wrap with order preserved.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
      launch(8'h10 + 8'(i), 2'(i % 4));
    end

    // Stall in PRESENT with ticks arriving; exactly one word consumed.
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("stall_valid0", tx_valid_o, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("stall_data", tx_data_o, 8'hA5);
      chk("stall_rd_addr", rd_addr_o, 2'd2);
      chk("stall_valid", tx_valid_o, 1'b1);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("stall_release_lvl", level_o, 3'd1);
    chk("stall_release_addr", rd_addr_o, 2'd3);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("no_queued_tick", tx_valid_o, 1'b0);

    // Push and handshake together at level 2.
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("pre_hs_level", level_o, 3'd2);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("push_hs_level", level_o, 3'd2);

    // Flush in PRESENT beats a simultaneous push and handshake.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("clr_pre_valid", tx_valid_o, 1'b1);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    chk("clr_valid", tx_valid_o, 1'b0);
    chk("clr_level", level_o, 3'd0);
    chk("clr_overflow", overflow_o, 1'b0);
    chk("clr_empty", empty_o, 1'b1);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    launch(8'h99, 2'd0);

    // Asynchronous reset in PRESENT, no clock edge needed.
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_pre_valid", tx_valid_o, 1'b1);
    #2 rst_i = 1'b0;
    #1 check_reset_values("async_rst");
    @(posedge clk);
    #1 rst_i = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    chk("push_after_reset", level_o, 3'd1);
    launch(8'h3C, 2'd0);

    // Randomized traffic checked by the per-cycle compare.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 199) == 0));
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
